if_stage_pipe: RTL and testbench

- Instruction-fetch stage plus IF/ID pipeline register for the 5-stage RV32I core.
- Owns the PC, drives the instruction-memory address and latches fetched instruction + PC into IF/ID.
- Consumes the load-use hazard unit's prevent_update_pc / prevent_update_reg_IF_ID stall requests.
- Consumes branch/jump redirects from EX, and supplies IF_ID rs1/rs2 fields back to the hazard unit.

---
 rtl/if_stage_pipe_pkg.sv | 18 +
 rtl/if_stage_pipe_if_id_reg.sv | 54 +++++
 rtl/if_stage_pipe.sv | 98 +++++++++
 tb/tb_if_stage_pipe.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/if_stage_pipe_pkg.sv
// Shared RV32I core constants: fetch widths, reset PC, bubble instruction, register-field positions.
package if_stage_pipe_pkg;

  localparam int          DEFAULT_PC_W      = 32;
  localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0013;
  localparam int          RS1_LSB           = 15;
  localparam int          RS2_LSB           = 20;

  function automatic logic [4:0] rs1_of(input logic [31:0] instr);
    return instr[RS1_LSB +: 5];
  endfunction

  function automatic logic [4:0] rs2_of(input logic [31:0] instr);
    return instr[RS2_LSB +: 5];
  endfunction

endpackage

// File: rtl/if_stage_pipe_if_id_reg.sv
// IF/ID pipeline register; flush loads a bubble and takes priority over hold.
module if_stage_pipe_if_id_reg
  import if_stage_pipe_pkg::*;
#(
  parameter int          PC_W      = DEFAULT_PC_W,
  parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
  input  logic            clk,
  input  logic            arst,
  input  logic            flush_i,
  input  logic            hold_i,
  input  logic [PC_W-1:0] pc_i,
  input  logic [31:0]     instr_i,
  output logic [PC_W-1:0] pc_o,
  output logic [31:0]     instr_o,
  output logic            valid_o
);

  logic [PC_W-1:0] pc_q,    pc_d;
  logic [31:0]     instr_q, instr_d;
  logic            valid_q, valid_d;

  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    if (flush_i) begin
      pc_d    = '0;
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end else if (!hold_i) begin
      pc_d    = pc_i;
      instr_d = instr_i;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      pc_q    <= '0;
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
    end
  end

  assign pc_o    = pc_q;
  assign instr_o = instr_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/if_stage_pipe.sv
// Fetch stage: owns the PC, drives imem combinationally, feeds IF/ID one cycle later.
// Define IF_STAGE_PERF_CNT_EN to add stall_cnt / flush_cnt performance counters.
module if_stage_pipe
  import if_stage_pipe_pkg::*;
#(
  parameter int          PC_W      = DEFAULT_PC_W,
  parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
  input  logic            clk,
  input  logic            arst,
  input  logic            prevent_update_pc,
  input  logic            prevent_update_reg_IF_ID,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_pc,
  output logic [PC_W-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  output logic [PC_W-1:0] if_id_pc,
  output logic [31:0]     if_id_instr,
  output logic            if_id_valid,
  output logic [4:0]      IF_ID_rs1,
  output logic [4:0]      IF_ID_rs2
`ifdef IF_STAGE_PERF_CNT_EN
  ,
  output logic [31:0]     stall_cnt,
  output logic [31:0]     flush_cnt
`endif
);

  logic [PC_W-1:0] pc_q, pc_d;

  // A redirect wins over a stall so a taken branch is never lost behind a load-use bubble.
  always_comb begin
    pc_d = pc_q;
    if (redirect_valid) begin
      pc_d = redirect_pc;
    end else if (!prevent_update_pc) begin
      pc_d = pc_q + PC_W'(4);
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      pc_q <= RESET_PC[PC_W-1:0];
    end else begin
      pc_q <= pc_d;
    end
  end

  assign imem_addr = pc_q;

  if_stage_pipe_if_id_reg #(
    .PC_W      (PC_W),
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id_reg (
    .clk     (clk),
    .arst    (arst),
    .flush_i (redirect_valid),
    .hold_i  (prevent_update_reg_IF_ID),
    .pc_i    (pc_q),
    .instr_i (imem_rdata),
    .pc_o    (if_id_pc),
    .instr_o (if_id_instr),
    .valid_o (if_id_valid)
  );

  assign IF_ID_rs1 = rs1_of(if_id_instr);
  assign IF_ID_rs2 = rs2_of(if_id_instr);

`ifdef IF_STAGE_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (redirect_valid) begin
      flush_cnt_d = flush_cnt_q + 32'd1;
    end else if (prevent_update_pc) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_if_stage_pipe.sv
// Directed table-driven bench for if_stage_pipe with hand-computed PC / IF-ID expectations.
module tb_if_stage_pipe;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        arst;
  logic        prevent_update_pc;
  logic        prevent_update_reg_IF_ID;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_instr;
  logic        if_id_valid;
  logic [4:0]  IF_ID_rs1;
  logic [4:0]  IF_ID_rs2;
`ifdef IF_STAGE_PERF_CNT_EN
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;
`endif

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // Address-dependent memory image so every fetched word is distinct.
  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return {a[15:0], a[15:0]} ^ 32'h0155_8000;
  endfunction

  assign imem_rdata = mem_f(imem_addr);

  if_stage_pipe dut (
    .clk                      (clk),
    .arst                     (arst),
    .prevent_update_pc        (prevent_update_pc),
    .prevent_update_reg_IF_ID (prevent_update_reg_IF_ID),
    .redirect_valid           (redirect_valid),
    .redirect_pc              (redirect_pc),
    .imem_addr                (imem_addr),
    .imem_rdata               (imem_rdata),
    .if_id_pc                 (if_id_pc),
    .if_id_instr              (if_id_instr),
    .if_id_valid              (if_id_valid),
    .IF_ID_rs1                (IF_ID_rs1),
    .IF_ID_rs2                (IF_ID_rs2)
`ifdef IF_STAGE_PERF_CNT_EN
    ,
    .stall_cnt                (stall_cnt),
    .flush_cnt                (flush_cnt)
`endif
  );

  typedef struct {
    logic        rv;
    logic [31:0] rpc;
    logic        sp;
    logic        sr;
    logic [31:0] epc;
    logic [31:0] eifpc;
    logic        ev;
  } vec_t;

  vec_t tbl[21];

  function automatic vec_t mk(input logic rv, input logic [31:0] rpc, input logic sp,
                              input logic sr, input logic [31:0] epc,
                              input logic [31:0] eifpc, input logic ev);
    vec_t v;
    v.rv = rv; v.rpc = rpc; v.sp = sp; v.sr = sr;
    v.epc = epc; v.eifpc = eifpc; v.ev = ev;
    return v;
  endfunction

  task automatic drive(input logic rv, input logic [31:0] rpc, input logic sp, input logic sr);
    redirect_valid           = rv;
    redirect_pc              = rpc;
    prevent_update_pc        = sp;
    prevent_update_reg_IF_ID = sr;
  endtask

  task automatic step(input logic rv, input logic [31:0] rpc, input logic sp, input logic sr);
    drive(rv, rpc, sp, sr);
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] epc,
                       input logic [31:0] eifpc, input logic ev);
    logic [31:0] ei;
    logic [31:0] eip;
    logic [111:0] act, exp;
    ei  = ev ? mem_f(eifpc) : NOP;
    eip = ev ? eifpc : 32'h0;
    act = {imem_addr, if_id_pc, if_id_instr, if_id_valid, IF_ID_rs1, IF_ID_rs2, 5'd0};
    exp = {epc, eip, ei, ev, ei[19:15], ei[24:20], 5'd0};
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got pc=%h ifpc=%h instr=%h v=%b rs1=%0d rs2=%0d want pc=%h ifpc=%h instr=%h v=%b rs1=%0d rs2=%0d",
               name, imem_addr, if_id_pc, if_id_instr, if_id_valid, IF_ID_rs1, IF_ID_rs2,
               epc, eip, ei, ev, ei[19:15], ei[24:20]);
    end
  endtask

`ifdef IF_STAGE_PERF_CNT_EN
  task automatic check_cnt(input string name, input logic [31:0] es, input logic [31:0] ef);
    n_vec++;
    if (stall_cnt !== es || flush_cnt !== ef) begin
      n_bad++;
      $display("FAIL %s: got stall=%0d flush=%0d want stall=%0d flush=%0d",
               name, stall_cnt, flush_cnt, es, ef);
    end
  endtask
`endif

  initial begin
    tbl[0]  = mk(0, 32'h0,         0, 0, 32'h004,      32'h000,      1);
    tbl[1]  = mk(0, 32'h0,         0, 0, 32'h008,      32'h004,      1);
    tbl[2]  = mk(0, 32'h0,         0, 0, 32'h00C,      32'h008,      1);
    tbl[3]  = mk(0, 32'h0,         0, 0, 32'h010,      32'h00C,      1);
    tbl[4]  = mk(0, 32'h0,         1, 1, 32'h010,      32'h00C,      1);
    tbl[5]  = mk(0, 32'h0,         0, 0, 32'h014,      32'h010,      1);
    tbl[6]  = mk(0, 32'h0,         0, 0, 32'h018,      32'h014,      1);
    tbl[7]  = mk(0, 32'h0,         0, 0, 32'h01C,      32'h018,      1);
    tbl[8]  = mk(0, 32'h0,         0, 0, 32'h020,      32'h01C,      1);
    tbl[9]  = mk(1, 32'h100,       0, 0, 32'h100,      32'h0,        0);
    tbl[10] = mk(0, 32'h0,         0, 0, 32'h104,      32'h100,      1);
    tbl[11] = mk(1, 32'h200,       1, 1, 32'h200,      32'h0,        0);
    tbl[12] = mk(0, 32'h0,         0, 0, 32'h204,      32'h200,      1);
    tbl[13] = mk(0, 32'h0,         1, 0, 32'h204,      32'h204,      1);
    tbl[14] = mk(0, 32'h0,         0, 1, 32'h208,      32'h204,      1);
    tbl[15] = mk(0, 32'h0,         0, 0, 32'h20C,      32'h208,      1);
    tbl[16] = mk(1, 32'hFFFF_FFFC, 0, 0, 32'hFFFF_FFFC, 32'h0,       0);
    tbl[17] = mk(0, 32'h0,         0, 0, 32'h000,      32'hFFFF_FFFC, 1);
    tbl[18] = mk(0, 32'h0,         0, 0, 32'h004,      32'h000,      1);
    tbl[19] = mk(1, 32'h102,       0, 1, 32'h102,      32'h0,        0);
    tbl[20] = mk(0, 32'h0,         0, 0, 32'h106,      32'h102,      1);

    arst = 1'b1;
    drive(0, 32'h0, 0, 0);
    #12;
    arst = 1'b0;
    #1;
    check("reset_state", 32'h0, 32'h0, 0);
`ifdef IF_STAGE_PERF_CNT_EN
    check_cnt("reset_cnt", 0, 0);
`endif

    for (int i = 0; i < 21; i++) begin
      step(tbl[i].rv, tbl[i].rpc, tbl[i].sp, tbl[i].sr);
      check($sformatf("vec%0d", i), tbl[i].epc, tbl[i].eifpc, tbl[i].ev);
    end
`ifdef IF_STAGE_PERF_CNT_EN
    check_cnt("table_cnt", 2, 4);
`endif

    // Asynchronous reset between edges while a stall is pending.
    drive(0, 32'h0, 1, 1);
    #3;
    arst = 1'b1;
    #1;
    check("async_rst_now", 32'h0, 32'h0, 0);
    @(posedge clk);
    #1;
    check("async_rst_hold", 32'h0, 32'h0, 0);
`ifdef IF_STAGE_PERF_CNT_EN
    check_cnt("async_rst_cnt", 0, 0);
`endif
    #2;
    drive(0, 32'h0, 0, 0);
    arst = 1'b0;
    #1;
    check("rst_release", 32'h0, 32'h0, 0);
    step(0, 32'h0, 0, 0);
    check("first_fetch", 32'h004, 32'h000, 1);

    for (int i = 0; i < 3; i++) begin
      step(0, 32'h0, 1, 1);
      check($sformatf("stall%0d", i), 32'h004, 32'h000, 1);
    end
    step(1, 32'h040, 0, 0);
    check("redir_a", 32'h040, 32'h0, 0);
    step(1, 32'h080, 0, 0);
    check("redir_b", 32'h080, 32'h0, 0);
`ifdef IF_STAGE_PERF_CNT_EN
    check_cnt("perf_cnt", 3, 2);
`endif
    step(0, 32'h0, 0, 0);
    check("after_redir", 32'h084, 32'h080, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
